// File: rtl/i2c_pwm_pkg.sv
// Shared types and constants for the I2C PWM-duty write master.
package i2c_pwm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ADDR  = 3'd2,
    ACK1  = 3'd3,
    DATA  = 3'd4,
    ACK2  = 3'd5,
    STOP  = 3'd6
  } state_e;

  typedef enum logic [1:0] {
    Q0 = 2'd0,
    Q1 = 2'd1,
    Q2 = 2'd2,
    Q3 = 2'd3
  } quarter_e;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b0101010;
  localparam int unsigned TICK_CNT_W = 16;
  localparam int unsigned GAP_CNT_W  = 17;
  localparam int unsigned SLOT_QUARTERS = 4;

  // Address phase byte for a write: 7-bit address followed by R/W = 0.
  function automatic logic [7:0] addr_byte(input logic [6:0] addr);
    return {addr, 1'b0};
  endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-SCL-period tick generator: counts 0..CLK_DIV-1 while enabled, held at 0 otherwise.
module i2c_tick_gen
  import i2c_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  output logic tick_o
);

  localparam logic [TICK_CNT_W-1:0] LAST = TICK_CNT_W'(CLK_DIV - 1);

  logic [TICK_CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (en_i && (cnt_q != LAST)) cnt_d = cnt_q + 1'b1;
  end

  // NOTE: registers use <= so every flop samples the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/i2c_pwm_master.sv
// I2C write-only master: sends {SLAVE_ADDR,W} then one duty byte, reports ACK/NACK.
module i2c_pwm_master
  import i2c_pwm_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 250,
  parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       duty_valid,
  input  logic [7:0] duty_data,
  output logic       duty_ready,
  output logic       scl_oe,
  output logic       sda_oe,
  input  logic       sda_i,
  output logic       busy,
  output logic       done,
  output logic       nack
);

  // Extra idle time after done so the bus rests released for a full slot
  // (STOP already provides the first half slot).
  localparam logic [GAP_CNT_W-1:0] IDLE_GAP = GAP_CNT_W'(2 * CLK_DIV);

  state_e                 state_q, state_d;
  quarter_e               quarter_q, quarter_d;
  logic [2:0]             bit_q, bit_d;
  logic [15:0]            shift_q, shift_d;
  logic                   nack_q, nack_d;
  logic                   done_q, done_d;
  logic                   ready_q, ready_d;
  logic [GAP_CNT_W-1:0]   guard_q, guard_d;
  logic                   tick;

  i2c_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk    (clk),
    .rst    (rst),
    .en_i   (state_q != IDLE),
    .tick_o (tick)
  );

  // NOTE: every variable gets a default first so no path through the block infers a latch.
  always_comb begin
    state_d   = state_q;
    quarter_d = quarter_q;
    bit_d     = bit_q;
    shift_d   = shift_q;
    nack_d    = nack_q;
    done_d    = 1'b0;
    guard_d   = guard_q;

    if (state_q == IDLE) begin
      if (guard_q != '0) guard_d = guard_q - 1'b1;
      if (duty_valid && ready_q) begin
        state_d   = START;
        quarter_d = Q0;
        bit_d     = '0;
        shift_d   = {addr_byte(SLAVE_ADDR), duty_data};
        nack_d    = 1'b0;
      end
    end else if (tick) begin
      quarter_d = quarter_e'(quarter_q + 2'd1);
      if ((quarter_q == Q2) && ((state_q == ACK1) || (state_q == ACK2)) && sda_i)
        nack_d = 1'b1;
      if (quarter_q == Q3) begin
        case (state_q)
          START: begin
            state_d = ADDR;
            bit_d   = '0;
          end
          ADDR, DATA: begin
            shift_d = {shift_q[14:0], 1'b0};
            bit_d   = bit_q + 3'd1;
            if (bit_q == 3'd7) state_d = (state_q == ADDR) ? ACK1 : ACK2;
          end
          ACK1: begin
            state_d = nack_q ? STOP : DATA;
            bit_d   = '0;
          end
          ACK2: state_d = STOP;
          STOP: begin
            state_d = IDLE;
            done_d  = 1'b1;
            guard_d = IDLE_GAP;
          end
          default: state_d = IDLE;
        endcase
      end
    end

    ready_d = (state_d == IDLE) && !done_d && (guard_d == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      quarter_q <= Q0;
      bit_q     <= '0;
      shift_q   <= '0;
      nack_q    <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b0;
      guard_q   <= '0;
    end else begin
      state_q   <= state_d;
      quarter_q <= quarter_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      nack_q    <= nack_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
      guard_q   <= guard_d;
    end
  end

  // Line drivers decode straight from registered state, so reset releases both lines at once.
  always_comb begin
    scl_oe = 1'b0;
    sda_oe = 1'b0;
    case (state_q)
      START: begin
        sda_oe = 1'b1;
        scl_oe = quarter_q[1];
      end
      ADDR, DATA: begin
        scl_oe = !quarter_q[1];
        sda_oe = !shift_q[15];
      end
      ACK1, ACK2: scl_oe = !quarter_q[1];
      STOP: begin
        scl_oe = (quarter_q == Q0);
        sda_oe = !quarter_q[1];
      end
      default: ;
    endcase
  end

  assign duty_ready = ready_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign nack       = nack_q;

endmodule

// File: tb/tb_i2c_pwm_master.sv
// Directed bench: open-drain bus, behavioural I2C PWM slave, hand-computed timing/data.
module tb_i2c_pwm_master;

  localparam int unsigned CLK_DIV = 4;
  localparam int GOOD_LAT  = 80 * CLK_DIV;
  localparam int NACK_LAT  = 44 * CLK_DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       duty_valid = 1'b0;
  logic [7:0] duty_data = 8'h00;
  logic       duty_ready, scl_oe, sda_oe, sda_i, busy, done, nack;

  i2c_pwm_master #(.CLK_DIV(CLK_DIV), .SLAVE_ADDR(7'b0101010)) dut (
    .clk        (clk),
    .rst        (rst),
    .duty_valid (duty_valid),
    .duty_data  (duty_data),
    .duty_ready (duty_ready),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_i),
    .busy       (busy),
    .done       (done),
    .nack       (nack)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Open-drain bus plus slave model sampled on the falling clock edge.
  logic slv_pull = 1'b0;
  logic scl_bus, sda_bus;
  assign scl_bus = ~scl_oe;
  assign sda_bus = ~(sda_oe | slv_pull);
  assign sda_i   = sda_bus;

  logic       scl_prev = 1'b1, sda_prev = 1'b1;
  int         bit_cnt = 0, byte_idx = 0;
  logic [7:0] sh = 8'h00;
  logic [7:0] bytes_q[$];
  int         starts = 0, stops = 0, last_stop_cyc = 0, min_gap = 1000000;
  bit         ack_addr = 1'b1, ack_data = 1'b1;
  logic [7:0] duty_reg = 8'h00;

  always @(negedge clk) begin
    if (scl_prev && scl_bus && sda_prev && !sda_bus) begin
      starts++;
      if (stops > 0 && (cyc - last_stop_cyc) < min_gap) min_gap = cyc - last_stop_cyc;
      bit_cnt  = 0;
      byte_idx = 0;
    end else if (scl_prev && scl_bus && !sda_prev && sda_bus) begin
      stops++;
      last_stop_cyc = cyc;
      bit_cnt = 0;
    end else if (!scl_prev && scl_bus) begin
      if (bit_cnt < 8) begin
        sh = {sh[6:0], sda_bus};
        bit_cnt++;
        if (bit_cnt == 8) begin
          bytes_q.push_back(sh);
          if (byte_idx == 1 && ack_data && bytes_q.size() >= 2 && bytes_q[0] == 8'h54)
            duty_reg = sh;
        end
      end else begin
        bit_cnt = 0;
        byte_idx++;
      end
    end else if (scl_prev && !scl_bus) begin
      slv_pull = (bit_cnt == 8) && ((byte_idx == 0) ? (ack_addr && sh == 8'h54) : ack_data);
    end
    scl_prev = scl_bus;
    sda_prev = sda_bus;
  end

  logic [7:0] pwm_cnt = 8'h00;
  always @(posedge clk) pwm_cnt <= pwm_cnt + 8'd1;

  task automatic clear_bus_log();
    bytes_q.delete();
    starts  = 0;
    stops   = 0;
    min_gap = 1000000;
  endtask

  task automatic run_write(input logic [7:0] d, input int exp_lat, input bit exp_nack,
                           input string tag);
    int n, t0;
    n = 0;
    @(negedge clk);
    while (!duty_ready && n < 200) begin @(negedge clk); n++; end
    check({tag, "_ready"}, duty_ready, 1);
    duty_valid = 1'b1;
    duty_data  = d;
    @(negedge clk);
    t0 = cyc;
    duty_valid = 1'b0;
    duty_data  = ~d;
    check({tag, "_busy"}, busy, 1);
    check({tag, "_ready_busy"}, duty_ready, 0);
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    check({tag, "_latency"}, cyc - t0, exp_lat);
    check({tag, "_nack"}, nack, exp_nack);
    check({tag, "_ready_done"}, duty_ready, 0);
    @(negedge clk);
    check({tag, "_done_pulse"}, done, 0);
    check({tag, "_idle_bus"}, {scl_oe, sda_oe, busy}, 3'b000);
  endtask

  initial begin
    int n, t0, d1;
    int hi;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", duty_ready, 0);
    check("rst_lines", {scl_oe, sda_oe}, 2'b00);
    check("rst_flags", {busy, done, nack}, 3'b000);
    rst = 1'b0;
    @(negedge clk);
    check("rst_ready_after", duty_ready, 1);

    // Good write
    clear_bus_log();
    ack_addr = 1'b1; ack_data = 1'b1;
    run_write(8'hB3, GOOD_LAT, 1'b0, "ack");
    check("ack_nbytes", bytes_q.size(), 2);
    if (bytes_q.size() == 2) begin
      check("ack_addr_byte", bytes_q[0], 8'h54);
      check("ack_data_byte", bytes_q[1], 8'hB3);
    end
    check("ack_start_stop", {starts[7:0], stops[7:0]}, 16'h0101);

    // Address NACK
    clear_bus_log();
    ack_addr = 1'b0; ack_data = 1'b1;
    run_write(8'h10, NACK_LAT, 1'b1, "anack");
    check("anack_nbytes", bytes_q.size(), 1);
    check("anack_start_stop", {starts[7:0], stops[7:0]}, 16'h0101);

    // Data NACK
    clear_bus_log();
    ack_addr = 1'b1; ack_data = 1'b0;
    run_write(8'h66, GOOD_LAT, 1'b1, "dnack");
    check("dnack_nbytes", bytes_q.size(), 2);

    // Back-to-back with duty_valid held
    clear_bus_log();
    ack_addr = 1'b1; ack_data = 1'b1;
    @(negedge clk);
    duty_valid = 1'b1;
    duty_data  = 8'h00;
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    duty_data = 8'hFF;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    d1 = cyc;
    check("b2b_done1", done, 1);
    check("b2b_ready_done", duty_ready, 0);
    @(negedge clk);
    n = 0;
    while (!busy && n < 200) begin @(negedge clk); n++; end
    check("b2b_accept2_after_done", (cyc > d1) && busy, 1);
    duty_valid = 1'b0;
    t0 = cyc;
    n = 0;
    while (!done && n < 1000) begin @(negedge clk); n++; end
    check("b2b_latency2", cyc - t0, GOOD_LAT);
    check("b2b_nack", nack, 0);
    check("b2b_nbytes", bytes_q.size(), 4);
    if (bytes_q.size() == 4) begin
      check("b2b_data1", bytes_q[1], 8'h00);
      check("b2b_addr2", bytes_q[2], 8'h54);
      check("b2b_data2", bytes_q[3], 8'hFF);
    end
    check("b2b_start_stop", {starts[7:0], stops[7:0]}, 16'h0202);
    check("b2b_idle_gap", min_gap >= int'(4 * CLK_DIV), 1);

    // Reset during DATA bit 3 (slot 13, Q1: SCL low, bit value 0 of 0xA5)
    clear_bus_log();
    repeat (20) @(negedge clk);
    n = 0;
    while (!duty_ready && n < 200) begin @(negedge clk); n++; end
    duty_valid = 1'b1;
    duty_data  = 8'hA5;
    @(negedge clk);
    t0 = cyc;
    duty_valid = 1'b0;
    while (cyc - t0 < 13 * 16 + 4) @(negedge clk);
    check("mid_scl_low", scl_oe, 1);
    check("mid_sda_bit3", sda_oe, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_lines", {scl_oe, sda_oe}, 2'b00);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", duty_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_no_done", done, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_ready_after", duty_ready, 1);
    check("mid_rst_no_done_after", done, 0);
    clear_bus_log();
    run_write(8'h3C, GOOD_LAT, 1'b0, "post_rst");
    if (bytes_q.size() >= 2) check("post_rst_data", bytes_q[bytes_q.size()-1], 8'h3C);
    else check("post_rst_nbytes", bytes_q.size(), 2);

    // End-to-end with the PWM slave model
    clear_bus_log();
    run_write(8'h40, GOOD_LAT, 1'b0, "e2e");
    check("e2e_duty_reg", duty_reg, 8'd64);
    hi = 0;
    for (int i = 0; i < 256; i++) begin
      @(negedge clk);
      if (pwm_cnt < duty_reg) hi++;
    end
    check("e2e_pwm_high", hi, 64);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
